// File: rtl/fetch_queue_unit_pkg.sv
// Shared types and helpers for the decoupled instruction-fetch front end.
package fetch_queue_unit_pkg;

  // One buffered fetch result: the address it was fetched from and the word returned.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [3:0] RMASK_WORD = 4'b1111;
  localparam logic [3:0] RMASK_NONE = 4'b0000;

  // Force an address onto a 32-bit word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue_unit_fifo.sv
// Fetch queue storage with a registered head entry, plus its overflow checker.
module fetch_fifo
  import fetch_queue_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  entry_t        i_push_data,
  input  logic          i_pop,
  input  logic          i_flush,
  output entry_t        o_head,
  output logic [CW-1:0] o_occupancy,
  output logic          o_empty,
  output logic          o_full
);

  entry_t        r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  entry_t        r_head;

  logic          w_push;
  logic          w_pop;
  logic [PW-1:0] w_rptr_nxt;
  logic [CW-1:0] w_count_after_pop;
  logic [CW-1:0] w_count_nxt;
  entry_t        w_head_nxt;

  // Next-state for count and the head register; a push into an (effectively) empty queue
  // lands directly in the head so it is visible the cycle after the push.
  always_comb begin
    w_push            = i_push & ~i_flush;
    w_pop             = i_pop & (r_count != '0);
    w_rptr_nxt        = w_pop ? (r_rptr + PW'(1)) : r_rptr;
    w_count_after_pop = w_pop ? (r_count - CW'(1)) : r_count;
    if (i_flush) begin
      w_count_nxt = '0;
    end else if (w_push) begin
      w_count_nxt = w_count_after_pop + CW'(1);
    end else begin
      w_count_nxt = w_count_after_pop;
    end
    if (i_flush) begin
      w_head_nxt = r_head;
    end else if (w_push && (w_count_after_pop == '0)) begin
      w_head_nxt = i_push_data;
    end else if (w_pop) begin
      w_head_nxt = r_mem[w_rptr_nxt];
    end else begin
      w_head_nxt = r_head;
    end
  end

  // Entry storage, written at the tail pointer.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wptr] <= i_push_data;
    end
  end

  // Pointers, count and head register; flush empties the queue and rewinds the pointers.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_head  <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_head  <= w_head_nxt;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      r_rptr  <= w_rptr_nxt;
      r_count <= w_count_nxt;
      r_head  <= w_head_nxt;
    end
  end

  assign o_head      = r_head;
  assign o_occupancy = r_count;
  assign o_empty     = (r_count == '0);
  assign o_full      = (r_count == CW'(DEPTH));

endmodule

// Enqueue into a full queue is only legal when the head leaves in the same cycle.
module fetch_fifo_chk (
  input logic clk,
  input logic i_rst_n,
  input logic i_push,
  input logic i_pop,
  input logic i_flush,
  input logic i_full
);

  a_no_overflow: assert property (@(posedge clk) disable iff (!i_rst_n)
    (i_push && i_full && !i_flush) |-> i_pop);

endmodule

// File: rtl/fetch_queue_unit.sv
// Decoupled fetch front end: owns the fetch PC, keeps one request in flight,
// buffers responses for decode and squashes responses made stale by a redirect.
module fetch_queue_unit
  import fetch_queue_unit_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h1eceb000,
  localparam int unsigned CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          redirect_en,
  input  logic [31:0]   redirect_pc,
  output logic [31:0]   imem_addr,
  output logic [3:0]    imem_rmask,
  input  logic [31:0]   imem_rdata,
  input  logic          imem_resp,
  output logic          de_valid,
  input  logic          de_ready,
  output logic [31:0]   de_pc,
  output logic [31:0]   de_instr,
  output logic [63:0]   de_order,
  output logic [CW-1:0] occupancy
);

  logic [31:0]  r_fetch_pc;
  logic [31:0]  r_req_pc;
  logic         r_outstanding;
  logic         r_stale;
  logic [63:0]  r_order;

  logic         w_pop;
  logic         w_enq;
  logic         w_out_after;
  logic [31:0]  w_used;
  logic         w_issue;
  logic         w_stale_nxt;
  fetch_entry_t w_push_entry;
  fetch_entry_t w_head;
  logic [CW-1:0] w_occ;
  logic         w_empty;
  logic         w_full;

  // Issue credit: slots already held (after this cycle's pop), the response landing now,
  // and any request still in flight must leave room for one more entry.
  always_comb begin
    w_pop        = ~w_empty & de_ready;
    w_out_after  = r_outstanding & ~imem_resp;
    w_enq        = imem_resp & ~r_stale & ~redirect_en;
    w_used       = 32'(w_occ) - 32'(w_pop) + 32'(w_enq) + 32'(w_out_after);
    w_issue      = rst & ~redirect_en & (~r_outstanding | imem_resp) & (w_used < DEPTH);
    w_push_entry = '{pc: r_req_pc, instr: imem_rdata};
  end

  // A redirect with a request in flight marks its response stale; any response clears it.
  always_comb begin
    if (redirect_en) begin
      w_stale_nxt = r_outstanding & ~imem_resp;
    end else if (imem_resp) begin
      w_stale_nxt = 1'b0;
    end else begin
      w_stale_nxt = r_stale;
    end
  end

  // Fetch PC, in-flight request tracking and the dequeue order counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc    <= RESET_PC;
      r_req_pc      <= 32'h0000_0000;
      r_outstanding <= 1'b0;
      r_stale       <= 1'b0;
      r_order       <= 64'd0;
    end else begin
      if (redirect_en) begin
        r_fetch_pc <= word_align(redirect_pc);
      end else if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      if (w_issue) begin
        r_req_pc      <= r_fetch_pc;
        r_outstanding <= 1'b1;
      end else if (imem_resp) begin
        r_outstanding <= 1'b0;
      end
      r_stale <= w_stale_nxt;
      if (w_pop) begin
        r_order <= r_order + 64'd1;
      end
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk         (clk),
    .i_rst_n     (rst),
    .i_push      (w_enq),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .i_flush     (redirect_en),
    .o_head      (w_head),
    .o_occupancy (w_occ),
    .o_empty     (w_empty),
    .o_full      (w_full)
  );

  fetch_fifo_chk u_fifo_chk (
    .clk     (clk),
    .i_rst_n (rst),
    .i_push  (w_enq),
    .i_pop   (w_pop),
    .i_flush (redirect_en),
    .i_full  (w_full)
  );

  assign imem_addr  = r_fetch_pc;
  assign imem_rmask = w_issue ? RMASK_WORD : RMASK_NONE;
  assign de_valid   = ~w_empty;
  assign de_pc      = w_head.pc;
  assign de_instr   = w_head.instr;
  assign de_order   = r_order;
  assign occupancy  = w_occ;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit; the memory answers each request with ~addr.
module tb_fetch_queue_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        de_valid;
  logic        de_ready;
  logic [31:0] de_pc;
  logic [31:0] de_instr;
  logic [63:0] de_order;
  logic [2:0]  occupancy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mem_lat = 1;
  logic        pend;
  logic [31:0] paddr;
  int          cd;

  logic [31:0] req_addr[$];
  int          req_cyc[$];
  int          resp_cyc[$];
  logic [31:0] deq_pc[$];
  logic [31:0] deq_instr[$];
  logic [63:0] deq_order[$];
  int          deq_cyc[$];

  fetch_queue_unit #(.DEPTH(4), .RESET_PC(32'h1eceb000)) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_rmask  (imem_rmask),
    .imem_rdata  (imem_rdata),
    .imem_resp   (imem_resp),
    .de_valid    (de_valid),
    .de_ready    (de_ready),
    .de_pc       (de_pc),
    .de_instr    (de_instr),
    .de_order    (de_order),
    .occupancy   (occupancy)
  );

  always #5 clk = ~clk;

  // Memory: a request seen in cycle t is answered in cycle t+1+mem_lat with data ~addr.
  initial begin
    imem_resp = 1'b0; imem_rdata = 32'h0; pend = 1'b0; cd = 0; paddr = 32'h0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (!rst) begin
        pend = 1'b0; imem_resp = 1'b0; imem_rdata = 32'h0;
      end else if (pend && cd == 0) begin
        imem_resp = 1'b1; imem_rdata = ~paddr; pend = 1'b0; resp_cyc.push_back(cyc);
      end else begin
        imem_resp = 1'b0; imem_rdata = 32'h0;
        if (pend) cd--;
      end
      @(negedge clk);
      if (rst && imem_rmask == 4'hf) begin
        pend = 1'b1; paddr = imem_addr; cd = mem_lat;
        req_addr.push_back(imem_addr); req_cyc.push_back(cyc);
      end
    end
  end

  // Dequeue log.
  always @(negedge clk) begin
    if (rst && de_valid && de_ready) begin
      deq_pc.push_back(de_pc); deq_instr.push_back(de_instr);
      deq_order.push_back(de_order); deq_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic clear_deq();
    deq_pc.delete(); deq_instr.delete(); deq_order.delete(); deq_cyc.delete();
  endtask

  task automatic clear_logs();
    clear_deq(); req_addr.delete(); req_cyc.delete(); resp_cyc.delete();
  endtask

  task automatic wait_deq(input int n, input int budget);
    int k = 0;
    while (deq_pc.size() < n && k < budget) begin tick(); k++; end
    chk("deq_wait", 64'(deq_pc.size() >= n), 64'd1);
  endtask

  initial begin
    int k;
    rst = 1'b0; redirect_en = 1'b0; redirect_pc = 32'h0; de_ready = 1'b0;
    repeat (3) tick();
    // Reset state
    chk("rst_occ",   64'(occupancy), 64'd0);
    chk("rst_valid", 64'(de_valid),  64'd0);
    chk("rst_pc",    64'(de_pc),     64'd0);
    chk("rst_instr", 64'(de_instr),  64'd0);
    chk("rst_order", de_order,       64'd0);
    chk("rst_rmask", 64'(imem_rmask), 64'd0);
    chk("rst_addr",  64'(imem_addr), 64'h1eceb000);

    // Streaming with one idle cycle between request and response
    mem_lat = 1; de_ready = 1'b1; clear_logs(); rst = 1'b1;
    wait_deq(3, 60);
    chk("a_req0", 64'(req_addr[0]), 64'h1eceb000);
    chk("a_req1", 64'(req_addr[1]), 64'h1eceb004);
    chk("a_req2", 64'(req_addr[2]), 64'h1eceb008);
    chk("a_gap1", 64'(req_cyc[1] - req_cyc[0]), 64'd2);
    chk("a_gap2", 64'(req_cyc[2] - req_cyc[1]), 64'd2);
    chk("a_no_bypass", 64'(deq_cyc[0] - req_cyc[0]), 64'd3);
    chk("a_pc0", 64'(deq_pc[0]), 64'h1eceb000);
    chk("a_pc1", 64'(deq_pc[1]), 64'h1eceb004);
    chk("a_pc2", 64'(deq_pc[2]), 64'h1eceb008);
    chk("a_in0", 64'(deq_instr[0]), 64'he1314fff);
    chk("a_in1", 64'(deq_instr[1]), 64'he1314ffb);
    chk("a_in2", 64'(deq_instr[2]), 64'he1314ff7);
    chk("a_ord0", deq_order[0], 64'd0);
    chk("a_ord1", deq_order[1], 64'd1);
    chk("a_ord2", deq_order[2], 64'd2);

    // Fill with decode stalled: four enqueues, then issue stops
    rst = 1'b0; tick(); tick();
    clear_logs(); de_ready = 1'b0; rst = 1'b1;
    repeat (20) tick();
    chk("b_nreq",   64'(req_addr.size()), 64'd4);
    chk("b_req3",   64'(req_addr[3]), 64'h1eceb00c);
    chk("b_occ",    64'(occupancy), 64'd4);
    chk("b_rmask",  64'(imem_rmask), 64'd0);
    chk("b_valid",  64'(de_valid), 64'd1);
    chk("b_pc",     64'(de_pc), 64'h1eceb000);
    chk("b_instr",  64'(de_instr), 64'he1314fff);
    chk("b_order",  de_order, 64'd0);
    de_ready = 1'b1; #1;
    chk("b_resume_rmask", 64'(imem_rmask), 64'hf);
    chk("b_resume_addr",  64'(imem_addr), 64'h1eceb010);
    tick(); de_ready = 1'b0;
    chk("b_pop_occ",   64'(occupancy), 64'd3);
    chk("b_pop_pc",    64'(de_pc), 64'h1eceb004);
    chk("b_pop_order", de_order, 64'd1);

    // Asynchronous reset mid-stream with three entries queued
    #1; rst = 1'b0; #1;
    chk("f_occ",   64'(occupancy), 64'd0);
    chk("f_valid", 64'(de_valid), 64'd0);
    chk("f_pc",    64'(de_pc), 64'd0);
    chk("f_instr", 64'(de_instr), 64'd0);
    chk("f_order", de_order, 64'd0);
    chk("f_rmask", 64'(imem_rmask), 64'd0);
    chk("f_addr",  64'(imem_addr), 64'h1eceb000);
    tick(); tick();
    clear_logs(); mem_lat = 3; de_ready = 1'b1; rst = 1'b1;

    // Redirect while the request to 1eceb008 is in flight
    k = 0;
    while (req_addr.size() < 3 && k < 60) begin tick(); k++; end
    chk("c_wait", 64'(req_addr.size() >= 3), 64'd1);
    chk("c_refetch_pc",    64'(deq_pc[0]), 64'h1eceb000);
    chk("c_refetch_order", deq_order[0], 64'd0);
    redirect_pc = 32'h0000_0100; redirect_en = 1'b1;
    tick(); redirect_en = 1'b0; clear_deq();
    wait_deq(1, 60);
    chk("c_pc",      64'(deq_pc[0]), 64'h100);
    chk("c_instr",   64'(deq_instr[0]), 64'hfffffeff);
    chk("c_order",   deq_order[0], 64'd2);
    chk("c_req_addr", 64'(req_addr[3]), 64'h100);
    chk("c_req_cyc", 64'(req_cyc[3]), 64'(resp_cyc[2]));

    // Redirect coinciding with a response and a dequeue; unaligned target
    de_ready = 1'b0; clear_deq();
    k = 0;
    while (!(imem_resp && de_valid) && k < 60) begin tick(); k++; end
    chk("d_wait",       64'(imem_resp && de_valid), 64'd1);
    chk("d_head_pc",    64'(de_pc), 64'h104);
    chk("d_head_order", de_order, 64'd3);
    de_ready = 1'b1; redirect_pc = 32'h0000_0203; redirect_en = 1'b1; #1;
    chk("d_no_issue", 64'(imem_rmask), 64'd0);
    tick(); redirect_en = 1'b0; #1;
    chk("d_ndeq",   64'(deq_pc.size()), 64'd1);
    chk("d_deq_pc", 64'(deq_pc[0]), 64'h104);
    chk("d_deq_ord", deq_order[0], 64'd3);
    chk("d_occ",    64'(occupancy), 64'd0);
    chk("d_valid",  64'(de_valid), 64'd0);
    chk("d_order",  de_order, 64'd4);
    chk("d_addr",   64'(imem_addr), 64'h200);
    chk("d_rmask",  64'(imem_rmask), 64'hf);
    clear_deq();
    wait_deq(1, 60);
    chk("d_new_pc",    64'(deq_pc[0]), 64'h200);
    chk("d_new_instr", 64'(deq_instr[0]), 64'hfffffdff);
    chk("d_new_order", deq_order[0], 64'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
